// File: rtl/sensor_pattern_gen_if.sv
// Request and sensor-beam signal bundle for sensor_pattern_gen.
// The master side issues car requests and the slave side drives the C/D beams.
interface sensor_pattern_gen_if;
    logic enter_req;
    logic exit_req;
    logic C;
    logic D;
    logic busy;
    logic done;
    logic drop;

    modport master (
        output enter_req, exit_req,
        input  C, D, busy, done, drop
    );

    modport slave (
        input  enter_req, exit_req,
        output C, D, busy, done, drop
    );
endinterface

// File: rtl/sensor_pattern_gen.sv
// Turns entry/exit request pulses into the Gray-coded C/D beam sequence of a passing car.
// Each request can be buffered in a one-deep pending slot, so back-to-back cars chain without idle gaps.
module sensor_pattern_gen #(
    parameter int HOLD = 3,
    parameter int GAP  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sensor_pattern_gen_if.slave  bus
);
    localparam int MAXV = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PH1,
        S_PH2,
        S_PH3,
        S_GAPS
    } state_t;

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic          r_dir, w_dir_n;
    logic          r_pv, w_pv_n;
    logic          r_pd, w_pd_n;
    logic          r_c, r_d, r_busy, r_done, r_drop;
    logic          w_c_n, w_d_n, w_busy_n, w_done_n, w_drop_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_pv    <= 1'b0;
            r_pd    <= 1'b0;
            r_c     <= 1'b0;
            r_d     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_dir   <= w_dir_n;
            r_pv    <= w_pv_n;
            r_pd    <= w_pd_n;
            r_c     <= w_c_n;
            r_d     <= w_d_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_drop  <= w_drop_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + CW'(1);
        w_dir_n   = r_dir;
        w_pv_n    = r_pv;
        w_pd_n    = r_pd;
        w_drop_n  = 1'b0;

        if (r_state == S_IDLE) begin
            w_cnt_n = '0;
            if (bus.enter_req) begin
                w_state_n = S_PH1;
                w_dir_n   = 1'b0;
                if (bus.exit_req) begin
                    w_pv_n = 1'b1;
                    w_pd_n = 1'b1;
                end
            end else if (bus.exit_req) begin
                w_state_n = S_PH1;
                w_dir_n   = 1'b1;
            end
        end else begin
            // Busy: enter has priority for the slot; the loser of a simultaneous pair is dropped.
            if (bus.enter_req || bus.exit_req) begin
                if (!r_pv) begin
                    w_pv_n   = 1'b1;
                    w_pd_n   = !bus.enter_req;
                    w_drop_n = bus.enter_req && bus.exit_req;
                end else begin
                    w_drop_n = 1'b1;
                end
            end

            case (r_state)
                S_PH1: if (r_cnt == HOLD_LAST) begin
                    w_state_n = S_PH2;
                    w_cnt_n   = '0;
                end
                S_PH2: if (r_cnt == HOLD_LAST) begin
                    w_state_n = S_PH3;
                    w_cnt_n   = '0;
                end
                S_PH3: if (r_cnt == HOLD_LAST) begin
                    w_state_n = S_GAPS;
                    w_cnt_n   = '0;
                end
                S_GAPS: if (r_cnt == GAP_LAST) begin
                    w_cnt_n = '0;
                    // A request landing in the slot on this same edge chains straight away.
                    if (w_pv_n) begin
                        w_state_n = S_PH1;
                        w_dir_n   = w_pd_n;
                        w_pv_n    = 1'b0;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end

        w_c_n = 1'b0;
        w_d_n = 1'b0;
        case (w_state_n)
            S_PH1: begin
                w_c_n = !w_dir_n;
                w_d_n = w_dir_n;
            end
            S_PH2: begin
                w_c_n = 1'b1;
                w_d_n = 1'b1;
            end
            S_PH3: begin
                w_c_n = w_dir_n;
                w_d_n = !w_dir_n;
            end
            default: begin
                w_c_n = 1'b0;
                w_d_n = 1'b0;
            end
        endcase
        w_busy_n = (w_state_n != S_IDLE);
        w_done_n = (w_state_n == S_GAPS) && (w_cnt_n == GAP_LAST);
    end

    assign bus.C    = r_c;
    assign bus.D    = r_d;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.drop = r_drop;
endmodule

// File: tb/tb_sensor_pattern_gen.sv
// Scoreboard bench: two instances (HOLD=3/GAP=2 and HOLD=1/GAP=1) share stimulus; a timeline
// model of each car predicts {C,D,busy,done,drop} per cycle and a negedge monitor compares.
module tb_sensor_pattern_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sensor_pattern_gen_if ifa();
    sensor_pattern_gen_if ifb();

    sensor_pattern_gen #(.HOLD(3), .GAP(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    sensor_pattern_gen #(.HOLD(1), .GAP(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    logic [4:0] qa[$];
    logic [4:0] qb[$];
    int total = 0;
    int bad   = 0;

    int m_hold[2] = '{3, 1};
    int m_gap[2]  = '{2, 1};
    bit m_act[2];
    int m_t[2];
    bit m_dir[2];
    bit m_pv[2];
    bit m_pd[2];

    // Each car is a timeline of 3*HOLD+GAP cycles; position t selects the phase as t/HOLD.
    function automatic logic [4:0] model_step(input int k, input bit en, input bit ex, input bit rst);
        int cl;
        int ph;
        logic [1:0] cd;
        logic dn;
        logic dp;
        dp = 1'b0;
        if (rst) begin
            m_act[k] = 1'b0;
            m_pv[k]  = 1'b0;
            m_t[k]   = 0;
            return 5'b0;
        end
        cl = 3 * m_hold[k] + m_gap[k];
        if (!m_act[k]) begin
            if (en) begin
                m_act[k] = 1'b1;
                m_dir[k] = 1'b0;
                m_t[k]   = 0;
                if (ex) begin
                    m_pv[k] = 1'b1;
                    m_pd[k] = 1'b1;
                end
            end else if (ex) begin
                m_act[k] = 1'b1;
                m_dir[k] = 1'b1;
                m_t[k]   = 0;
            end
        end else begin
            if (en || ex) begin
                if (!m_pv[k]) begin
                    m_pv[k] = 1'b1;
                    m_pd[k] = !en;
                    dp      = en && ex;
                end else begin
                    dp = 1'b1;
                end
            end
            m_t[k] = m_t[k] + 1;
            if (m_t[k] == cl) begin
                if (m_pv[k]) begin
                    m_dir[k] = m_pd[k];
                    m_pv[k]  = 1'b0;
                    m_t[k]   = 0;
                end else begin
                    m_act[k] = 1'b0;
                end
            end
        end
        if (!m_act[k]) return {4'b0000, dp};
        ph = m_t[k] / m_hold[k];
        case (ph)
            0:       cd = m_dir[k] ? 2'b01 : 2'b10;
            1:       cd = 2'b11;
            2:       cd = m_dir[k] ? 2'b10 : 2'b01;
            default: cd = 2'b00;
        endcase
        dn = (m_t[k] == cl - 1);
        return {cd, 1'b1, dn, dp};
    endfunction

    task automatic step(input bit en, input bit ex, input bit rst);
        logic [4:0] ea;
        logic [4:0] eb;
        ifa.enter_req = en;
        ifa.exit_req  = ex;
        ifb.enter_req = en;
        ifb.exit_req  = ex;
        reset         = rst;
        ea = model_step(0, en, ex, rst);
        eb = model_step(1, en, ex, rst);
        @(posedge clk);
        qa.push_back(ea);
        qb.push_back(eb);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        logic [4:0] o;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            o = {ifa.C, ifa.D, ifa.busy, ifa.done, ifa.drop};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL h3g2 t=%0t {C,D,busy,done,drop} got=%b exp=%b", $time, o, e);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            o = {ifb.C, ifb.D, ifb.busy, ifb.done, ifb.drop};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL h1g1 t=%0t {C,D,busy,done,drop} got=%b exp=%b", $time, o, e);
            end
        end
    end

    initial begin
        ifa.enter_req = 1'b0;
        ifa.exit_req  = 1'b0;
        ifb.enter_req = 1'b0;
        ifb.exit_req  = 1'b0;
        reset = 1'b1;

        step(0, 0, 1);
        step(0, 0, 1);
        idle(2);
        // single enter, single exit
        step(1, 0, 0); idle(12);
        step(0, 1, 0); idle(12);
        // simultaneous pair chains enter then exit
        step(1, 1, 0); idle(24);
        // exit buffered at cycle 2, enter dropped at cycle 4
        step(1, 0, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0); step(1, 0, 0); idle(26);
        // reset at cycle 5 with the slot full, then a fresh car
        step(1, 0, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 0, 1); idle(3);
        step(1, 0, 0); idle(12);

        for (int i = 0; i < 3000; i++) begin
            bit en;
            bit ex;
            bit rs;
            en = ($urandom_range(0, 9) == 0);
            ex = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 199) == 0);
            step(en, ex, rs);
        end
        idle(20);

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL drain leftover_a=%0d leftover_b=%0d exp=0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sensor_pattern_gen.md
# sensor_pattern_gen

Generates the two-sensor light-beam waveform that a car makes when it passes through the lot gate. C is the outer beam and D is the inner beam. The block turns one-cycle entry/exit requests into the exact C/D phase sequence that the gate sensor FSM decodes into `enter`/`exit` pulses. It drives the sensor inputs in board self-test mode and in system-level benches. It has a one-deep request buffer so that back-to-back cars can be queued.

## Interface
- `HOLD`, default 3: cycles each beam phase (10/11/01) is held; legal range ≥1.
- `GAP`, default 2: cycles of C=D=0 after each car, before the next can start; legal range ≥1.
- `clk`  in  1  clock.
- `reset`  in  1  reset: synchronous, active-high.
- `enter_req`  in  1  request one entering car (C first); sampled every edge.
- `exit_req`  in  1  request one exiting car (D first); sampled every edge.
- `C`  out  1  outer beam blocked (registered).
- `D`  out  1  inner beam blocked (registered).
- `busy`  out  1  a car pattern is in progress.
- `done`  out  1  one-cycle pulse in the last GAP cycle of each car.
- `drop`  out  1  one-cycle pulse: a request was discarded because the buffer was full.

## Operation
- States: IDLE, PH1, PH2, PH3, GAPS. The direction bit `dir` (0 = enter, 1 = exit) is latched at the start of each car.
- Patterns {C,D}:
  - Enter: PH1=10, PH2=11, PH3=01, GAPS=00.
  - Exit: PH1=01, PH2=11, PH3=10, GAPS=00.
  - IDLE=00.
- Phase counter: width $clog2(max(HOLD,GAP)); clears on every state change.
  - PH1, PH2 and PH3 advance when count==HOLD-1.
  - GAPS ends when count==GAP-1.
- Request selection: if `enter_req` and `exit_req` are both high in the same cycle, enter wins. The exit request is treated as a second, simultaneous request (see buffering).
- IDLE:
  - A request at edge k moves to PH1 with `dir` latched.
  - A simultaneous second request goes into the pending slot.
- Pending slot: 1 entry, holding a valid bit and a direction bit.
  - A request arriving while `busy`=1 fills the slot if it is empty.
  - If the slot is already full, the request is discarded and `drop` pulses for 1 cycle.
  - If both requests arrive while busy, enter is buffered if the slot is empty. The exit request is dropped (one `drop` pulse).
- GAPS end: if the pending slot is valid, go directly to PH1 with the pending `dir` and clear the slot in the same edge. Otherwise go to IDLE.
- `busy` is 1 in PH1..GAPS and 0 only in IDLE.

## Timing
- Reset values: state IDLE, C=0, D=0, busy=0, done=0, drop=0, pending slot empty, counter 0.
- Reset mid-car: at the next edge all outputs return to their reset values. The current car and the pending car are abandoned, and no `done` pulse is produced.
- Start latency: a request sampled at edge k gives C/D = PH1 pattern and busy=1 from edge k. Output is registered, with no combinational path from input to output.
- Duration per car: 3·HOLD+GAP cycles of busy=1.
- `done` is high during the final GAPS cycle (count==GAP-1).
- Chaining: when a pending car chains, busy stays 1 continuously. PH1 of the next car starts the cycle after `done`, with no extra idle cycle.
- Requests are level-sampled. A request held high for N cycles while busy counts as N requests: the first one fills the slot and the rest are dropped. Callers must pulse requests.
- Exactly one phase transition occurs per edge, so C and D never change in the same edge from 10 to 01 or from 01 to 10. Every transition is Gray (1 bit), which matches the decoder's legal paths.

## Test plan
- Reset, then one `enter_req` pulse at cycle 0 (HOLD=3, GAP=2):
  - C/D = 10 in cycles 0-2, 11 in cycles 3-5, 01 in cycles 6-8, 00 in cycles 9-10.
  - done=1 only in cycle 10; busy=1 in cycles 0-10 and 0 from cycle 11.
  - A sensor FSM hooked to the outputs gives exactly one `enter` pulse.
- One `exit_req` pulse:
  - C/D = 01, 11, 10, 00, each phase 3 cycles and the gap 2 cycles.
  - The sensor FSM gives exactly one `exit` pulse and zero `enter` pulses.
- `enter_req` and `exit_req` high together at cycle 0 in IDLE:
  - An enter pattern runs first, then an exit pattern starts at cycle 11 with no idle gap.
  - busy stays 1 for cycles 0-21; done pulses at cycles 10 and 21; drop never asserts.
- During an enter car:
  - An `exit_req` pulse at cycle 2 is buffered.
  - An `enter_req` pulse at cycle 4 is dropped: drop=1 in cycle 4 only.
  - Only 2 cars are produced in total.
- Reset asserted at cycle 5 of a car with the pending slot full:
  - C=D=0 and busy=0 from cycle 5 onward.
  - No done pulse and no pending car; a fresh request after reset starts normally.
- HOLD=1, GAP=1:
  - Enter gives C/D = 10, 11, 01, 00 in one cycle each; busy lasts 4 cycles; done is in the 4th cycle.
